// File: rtl/imem_loader.sv
// Loads a 32-bit instruction stream into a byte store big-endian, one byte per cycle, and has a registered 4-byte fetch read port.
// Latency: an accepted word is fully written 4 cycles after acceptance; rd_data is valid 1 cycle after rd_addr.
// Backpressure: in_ready drops for the 4 write cycles and stays low once the load is done or the store is full.
module imem_loader #(
    parameter int DEPTH = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    input  logic        in_last,
    output logic        in_ready,
    input  logic [5:0]  rd_addr,
    output logic [31:0] rd_data,
    output logic        busy,
    output logic        done,
    output logic        full,
    output logic [4:0]  word_count
);

    typedef enum logic [2:0] {IDLE, WR0, WR1, WR2, WR3, DONE} state_t;

    localparam logic [6:0] DEPTH_L = 7'(DEPTH);

    state_t      state;
    logic [7:0]  mem [0:63];
    logic [31:0] hold_dat;
    logic        hold_last;
    logic [6:0]  wr_ptr;
    logic [6:0]  ptr_next;
    logic        at_end;
    logic [5:0]  rd_a1, rd_a2, rd_a3;

    assign ptr_next = wr_ptr + 7'd4;
    assign at_end   = (ptr_next == DEPTH_L);

    // Read addresses wrap naturally through the 6-bit adders.
    assign rd_a1 = rd_addr + 6'd1;
    assign rd_a2 = rd_addr + 6'd2;
    assign rd_a3 = rd_addr + 6'd3;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            hold_dat   <= '0;
            hold_last  <= 1'b0;
            wr_ptr     <= '0;
            word_count <= '0;
            in_ready   <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            full       <= 1'b0;
            rd_data    <= '0;
            for (int i = 0; i < 64; i++) begin
                mem[i] <= '0;
            end
        end else begin
            // Sampled before this edge's byte write lands, so a collision returns the old byte.
            rd_data <= {mem[rd_addr], mem[rd_a1], mem[rd_a2], mem[rd_a3]};

            case (state)
                IDLE: begin
                    if (in_valid) begin
                        hold_dat  <= in_data;
                        hold_last <= in_last;
                        in_ready  <= 1'b0;
                        busy      <= 1'b1;
                        state     <= WR0;
                    end
                end
                WR0: begin
                    mem[wr_ptr[5:0]] <= hold_dat[31:24];
                    state            <= WR1;
                end
                WR1: begin
                    mem[wr_ptr[5:0] + 6'd1] <= hold_dat[23:16];
                    state                   <= WR2;
                end
                WR2: begin
                    mem[wr_ptr[5:0] + 6'd2] <= hold_dat[15:8];
                    state                   <= WR3;
                end
                WR3: begin
                    mem[wr_ptr[5:0] + 6'd3] <= hold_dat[7:0];
                    wr_ptr                  <= ptr_next;
                    word_count              <= word_count + 5'd1;
                    busy                    <= 1'b0;
                    if (hold_last || at_end) begin
                        done  <= 1'b1;
                        full  <= at_end;
                        state <= DONE;
                    end else begin
                        in_ready <= 1'b1;
                        state    <= IDLE;
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed vector table, hand-written corner sequences and random traffic.
// Every cycle is also checked against a schedule-based model of byte writes.
module tb_imem_loader;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_last = 1'b0;
    logic        in_ready;
    logic [5:0]  rd_addr = '0;
    logic [31:0] rd_data;
    logic        busy;
    logic        done;
    logic        full;
    logic [4:0]  word_count;

    imem_loader #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .busy(busy), .done(done), .full(full), .word_count(word_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: a word accepted at cycle c writes byte k at cycle c+1+k and completes at c+4.
    int          cyc = 0;
    int          acc_cyc = -1000;
    logic [7:0]  m_mem [64];
    logic [31:0] m_word;
    logic        m_last;
    int          m_ptr, m_cnt;
    bit          m_done, m_full;
    logic [31:0] m_rd;

    task automatic model_step();
        int k;
        bit was_ready;
        cyc++;
        if (rst) begin
            foreach (m_mem[i]) m_mem[i] = 8'h00;
            acc_cyc = -1000;
            m_word = '0; m_last = 1'b0;
            m_ptr = 0; m_cnt = 0; m_done = 0; m_full = 0; m_rd = '0;
            return;
        end
        m_rd = {m_mem[rd_addr], m_mem[(rd_addr + 1) % 64],
                m_mem[(rd_addr + 2) % 64], m_mem[(rd_addr + 3) % 64]};
        was_ready = !m_done && (cyc >= acc_cyc + 5);
        k = cyc - acc_cyc - 1;
        if (k >= 0 && k < 4) begin
            m_mem[(m_ptr + k) % 64] = m_word[31 - 8*k -: 8];
            if (k == 3) begin
                m_ptr += 4;
                m_cnt++;
                if (m_last || m_ptr == DEPTH) m_done = 1;
                if (m_ptr == DEPTH) m_full = 1;
            end
        end
        if (was_ready && in_valid) begin
            acc_cyc = cyc;
            m_word  = in_data;
            m_last  = in_last;
        end
    endtask

    task automatic model_cmp();
        chk("m_in_ready", {31'd0, in_ready}, {31'd0, (!m_done && (cyc + 1 >= acc_cyc + 5))});
        chk("m_busy", {31'd0, busy}, {31'd0, (cyc - acc_cyc >= 0 && cyc - acc_cyc <= 3)});
        chk("m_done", {31'd0, done}, {31'd0, m_done});
        chk("m_full", {31'd0, full}, {31'd0, m_full});
        chk("m_word_count", {27'd0, word_count}, 32'(m_cnt));
        chk("m_rd_data", rd_data, m_rd);
    endtask

    task automatic tick(input logic r, input logic v, input logic [31:0] d,
                        input logic l, input logic [5:0] a);
        rst = r; in_valid = v; in_data = d; in_last = l; rd_addr = a;
        @(posedge clk);
        model_step();
        #1;
        model_cmp();
    endtask

    typedef struct {
        logic        r, v;
        logic [31:0] d;
        logic        l;
        logic [5:0]  a;
        logic        e_ready, e_busy, e_done;
        logic [4:0]  e_wc;
        logic [31:0] e_rd;
    } vec_t;

    vec_t tbl [10];

    initial begin
        // Single-word program with in_last, then reads and an ignored offer.
        tbl[0] = '{1, 0, 32'h0,        0, 0,  1, 0, 0, 0, 32'h0};
        tbl[1] = '{0, 1, 32'h8C220004, 1, 0,  0, 1, 0, 0, 32'h0};
        tbl[2] = '{0, 0, 32'h0,        0, 0,  0, 1, 0, 0, 32'h0};
        tbl[3] = '{0, 0, 32'h0,        0, 0,  0, 1, 0, 0, 32'h8C000000};
        tbl[4] = '{0, 0, 32'h0,        0, 0,  0, 1, 0, 0, 32'h8C220000};
        tbl[5] = '{0, 0, 32'h0,        0, 0,  0, 0, 1, 1, 32'h8C220000};
        tbl[6] = '{0, 0, 32'h0,        0, 0,  0, 0, 1, 1, 32'h8C220004};
        tbl[7] = '{0, 0, 32'h0,        0, 1,  0, 0, 1, 1, 32'h22000400};
        tbl[8] = '{0, 1, 32'hFFFFFFFF, 1, 0,  0, 0, 1, 1, 32'h8C220004};
        tbl[9] = '{0, 0, 32'h0,        0, 62, 0, 0, 1, 1, 32'h00008C22};

        for (int i = 0; i < 10; i++) begin
            tick(tbl[i].r, tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].a);
            chk($sformatf("vec%0d_in_ready", i), {31'd0, in_ready}, {31'd0, tbl[i].e_ready});
            chk($sformatf("vec%0d_busy", i),     {31'd0, busy},     {31'd0, tbl[i].e_busy});
            chk($sformatf("vec%0d_done", i),     {31'd0, done},     {31'd0, tbl[i].e_done});
            chk($sformatf("vec%0d_wc", i),       {27'd0, word_count}, {27'd0, tbl[i].e_wc});
            chk($sformatf("vec%0d_rd", i),       rd_data, tbl[i].e_rd);
        end

        // Fill the store with 16 words; the 17th offer must be ignored.
        tick(1, 0, 0, 0, 0);
        for (int w = 0; w < 16; w++) begin
            tick(0, 1, 32'(w), 0, 0);
            for (int j = 0; j < 4; j++) tick(0, 0, 0, 0, 0);
        end
        chk("fill_full", {31'd0, full}, 32'd1);
        chk("fill_done", {31'd0, done}, 32'd1);
        chk("fill_wc", {27'd0, word_count}, 32'd16);
        tick(0, 1, 32'hDEADBEEF, 0, 60);
        for (int j = 0; j < 5; j++) tick(0, 0, 0, 0, 60);
        chk("fill_wc_after_extra", {27'd0, word_count}, 32'd16);
        chk("fill_rd60", rd_data, 32'h0000000F);
        tick(0, 0, 0, 0, 62);
        chk("wrap_rd62", rd_data, 32'h000F0000);

        // in_valid held high with data changing every cycle: one capture per 5 cycles.
        tick(1, 0, 0, 0, 0);
        for (int c = 0; c < 25; c++) tick(0, 1, 32'h1000 + 32'(c), 0, 0);
        chk("hold_wc", {27'd0, word_count}, 32'd5);
        tick(0, 0, 0, 0, 4);
        chk("hold_word1", rd_data, 32'h00001005);
        tick(0, 0, 0, 0, 16);
        chk("hold_word4", rd_data, 32'h00001014);

        // Reset during WR2 of the second word clears everything.
        tick(1, 0, 0, 0, 0);
        tick(0, 1, 32'h11223344, 0, 0);
        for (int j = 0; j < 4; j++) tick(0, 0, 0, 0, 0);
        tick(0, 1, 32'h55667788, 0, 0);
        tick(0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0);
        tick(1, 1, 32'h99999999, 0, 0);
        chk("rst_mid_wc", {27'd0, word_count}, 32'd0);
        chk("rst_mid_ready", {31'd0, in_ready}, 32'd1);
        for (int a = 0; a < 64; a += 4) begin
            tick(0, 0, 0, 0, 6'(a));
            chk($sformatf("rst_mid_rd%0d", a), rd_data, 32'h0);
        end

        // Read-during-write on byte 5 returns the old byte, then the new one.
        tick(1, 0, 0, 0, 0);
        tick(0, 1, 32'h01020304, 0, 0);
        for (int j = 0; j < 4; j++) tick(0, 0, 0, 0, 0);
        tick(0, 1, 32'hA1B2C3D4, 0, 0);
        tick(0, 0, 0, 0, 4);
        tick(0, 0, 0, 0, 4);
        chk("rdw_old", rd_data, 32'hA1000000);
        tick(0, 0, 0, 0, 4);
        chk("rdw_new", rd_data, 32'hA1B20000);

        // Random traffic, reads and occasional resets against the model.
        for (int round = 0; round < 4; round++) begin
            tick(1, 0, 0, 0, 0);
            for (int c = 0; c < 300; c++) begin
                tick(($urandom_range(0, 99) < 2),
                     ($urandom_range(0, 99) < 70),
                     $urandom(),
                     ($urandom_range(0, 99) < (round == 0 ? 0 : 8)),
                     6'($urandom_range(0, 63)));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 64, meaning byte capacity of the internal store (byte addresses 0..DEPTH-1).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 SHALL have port rst  input  1  reset; one clock, reset is synchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  producer offers an instruction word.
REQ-005 SHALL have port in_data  input  32  instruction word, bit 31 = MSB.
REQ-006 SHALL have port in_last  input  1  qualifies in_data as final word of the program.
REQ-007 SHALL have port in_ready  output  1  loader accepts a word this cycle.
REQ-008 SHALL have port rd_addr  input  6  byte address for the fetch-side read port.
REQ-009 SHALL have port rd_data  output  32  registered big-endian word read from rd_addr.
REQ-010 SHALL have port busy  output  1  a word is being written to the store.
REQ-011 SHALL have port done  output  1  program load complete (last word written or store full).
REQ-012 SHALL have port full  output  1  DEPTH bytes written.
REQ-013 SHALL have port word_count  output  5  number of words fully written (0..16).

Function
REQ-014 SHALL implement states IDLE, WR0, WR1, WR2, WR3, DONE.
REQ-015 In IDLE: in_ready=1, busy=0; in_valid=1 captures in_data and in_last into hold registers, next state WR0.
REQ-016 Handshake: word transfers only when in_valid && in_ready on a posedge; in_data/in_last ignored otherwise.
REQ-017 WR0..WR3: in_ready=0, busy=1; one byte written per cycle: WR0 hold[31:24] at wr_ptr, WR1 hold[23:16] at wr_ptr+1, WR2 hold[15:8] at wr_ptr+2, WR3 hold[7:0] at wr_ptr+3.
REQ-018 On WR3 exit: wr_ptr += 4, word_count += 1; next state DONE if captured in_last=1 or wr_ptr+4 == DEPTH, else IDLE.
REQ-019 Latency: accepted word fully visible in store 4 cycles after acceptance edge; next acceptance earliest 5 cycles after previous.
REQ-020 full SHALL assert in the cycle after WR3 when wr_ptr reaches DEPTH; full and done then hold until rst.
REQ-021 In DONE: in_ready=0, busy=0, done=1; further in_valid ignored, store unchanged.
REQ-022 wr_ptr SHALL be 7 bits wide so DEPTH=64 is representable; store write address = wr_ptr[5:0] + byte offset.
REQ-023 Read port: every posedge, rd_data <= {mem[a], mem[a+1], mem[a+2], mem[a+3]}, a=rd_addr, additions mod 64 (wrap 63 -> 0).
REQ-024 Read-during-write to same byte SHALL return the old byte (read-before-write); new value visible on next read.
REQ-025 Read port SHALL operate in every state including reset cycle output rule of REQ-027.
REQ-026 rd_addr unaligned values SHALL be honoured byte-exactly (no forced alignment).

Reset
REQ-027 rst=1 at posedge: state=IDLE, wr_ptr=0, word_count=0, done=0, full=0, busy=0, rd_data=0, all store bytes=0, hold registers=0.
REQ-028 rst mid-word (any of WR0..WR3) SHALL abandon the word; bytes already written are cleared by REQ-027.
REQ-029 rst has priority over in_valid in the same cycle; no word accepted on a reset edge.
REQ-030 in_ready SHALL be 1 in the first cycle after rst deasserts.

Verification
REQ-031 Load 0x8C220004 with in_last=1 -> in_ready low 4 cycles, done=1, word_count=1; rd_addr=0 -> rd_data=0x8C220004 next edge; rd_addr=1 -> 0x22000400.
REQ-032 Stream 16 words 0x00000000..0x0000000F, in_last=0 -> full=1, done=1, word_count=16; 17th in_valid ignored; rd_addr=60 -> 0x0000000F.
REQ-033 Wrap read: after REQ-032 load, rd_addr=62 -> rd_data={mem[62],mem[63],mem[0],mem[1]}=0x000F0000.
REQ-034 Hold in_valid=1 continuously with changing in_data -> only words present in IDLE cycles captured, spacing exactly 5 cycles.
REQ-035 Assert rst during WR2 of second word -> next cycle word_count=0, in_ready=1, rd_data=0 for all addresses.
REQ-036 rd_addr=4 while WR1 writes byte 5 -> rd_data shows old byte 5; following read shows new byte.
